aclk_controller: RTL

Sequencing FSM for the alarm-clock datapath. It decodes keypad and button activity into the control strobes for the key shift register, the alarm and current-time load paths, and the LCD display select (`show_a`, `show_current_time`) consumed by `aclk_lcd_display`. It sits between the keypad front end and the time registers and display, and runs from the system clock with a one-second tick for entry timeout.

---
 rtl/aclk_controller.sv | 120 ++++++++++++
 1 files changed

// File: rtl/aclk_controller.sv
// rtl/aclk_controller.sv - alarm-clock sequencing FSM (keypad entry, loads, LCD select)
// Optional entry timeout counter built when ACLK_CTRL_TIMEOUT_EN is defined.
module aclk_controller #(
  parameter int         TIMEOUT_SEC = 10,
  parameter logic [3:0] NOKEY       = 4'd10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_a,
  output logic       show_current_time
);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t state;
  state_t state_next;
  logic   timeout;
  logic   key_down;

  assign key_down = (key != NOKEY);

`ifdef ACLK_CTRL_TIMEOUT_EN
  localparam logic [3:0] COUNT_LAST = 4'(TIMEOUT_SEC - 1);

  logic [3:0] count;
  logic       in_entry;

  assign in_entry = (state == KEY_WAITED) || (state == KEY_ENTRY);
  assign timeout  = in_entry && one_second && (count == COUNT_LAST);

  // Any state change restarts the count, so each wait state gets a full window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 4'd0;
    end else if (!in_entry || (state_next != state)) begin
      count <= 4'd0;
    end else if (one_second) begin
      count <= count + 4'd1;
    end
  end
`else
  logic unused_one_second;

  assign unused_one_second = one_second;
  assign timeout           = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= SHOW_TIME;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)  state_next = SHOW_ALARM;
        else if (key_down) state_next = KEY_STORED;
      end
      KEY_STORED: state_next = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_down)    state_next = KEY_ENTRY;
        else if (timeout) state_next = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     state_next = SET_ALARM_TIME;
        else if (time_button) state_next = SET_CURRENT_TIME;
        else if (key_down)    state_next = KEY_STORED;
        else if (timeout)     state_next = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_next = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_next = SHOW_TIME;
      SET_CURRENT_TIME: state_next = SHOW_TIME;
      default:          state_next = SHOW_TIME;
    endcase
  end

  always_comb begin
    shift             = 1'b0;
    load_new_a        = 1'b0;
    load_new_c        = 1'b0;
    show_a            = 1'b0;
    show_current_time = 1'b0;
    case (state)
      SHOW_TIME:  show_current_time = 1'b1;
      KEY_STORED: shift = 1'b1;
      SHOW_ALARM: show_a = 1'b1;
      SET_ALARM_TIME: begin
        load_new_a        = 1'b1;
        show_current_time = 1'b1;
      end
      SET_CURRENT_TIME: begin
        load_new_c        = 1'b1;
        show_current_time = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
